mic1_mem_arbiter: RTL
=====================

MIC1_MEM_ARBITER -- requirements
Module: mic1_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of main memory (256 words).
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 Parameter MEM_LAT, default 1, main-memory read latency in cycles (range 1-4).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-008 cpu_we  in  1  CPU write enable, qualified by cpu_req.
REQ-009 cpu_addr  in  ADDR_W  CPU word address.
REQ-010 cpu_wdata  in  DATA_W  CPU write data.
REQ-011 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-012 cpu_rdata  out  DATA_W  CPU read data, valid from cpu_ack until the next CPU read completes.
REQ-013 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same directions, widths and meaning as the cpu_* ports, for the UART debug/loader port.
REQ-014 dbg_halt  in  1  when high, CPU requests are not granted.
REQ-015 mem_en  out  1  memory access strobe, exactly one cycle per transaction.
REQ-016 mem_we  out  1  memory write enable, valid with mem_en.
REQ-017 mem_addr  out  ADDR_W  memory address, valid with mem_en.
REQ-018 mem_wdata  out  DATA_W  memory write data, valid with mem_en.
REQ-019 mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT and ACK.
REQ-022 IDLE: if any eligible request, latch the winner's we/addr/wdata and go to ISSUE; otherwise stay in IDLE.
REQ-023 The CPU is eligible when cpu_req=1 and dbg_halt=0; the debug port is eligible when dbg_req=1.
REQ-024 Arbitration SHALL be round-robin: when both are eligible, grant the port not granted last; last_grant resets to debug, so the CPU wins the first tie.
REQ-025 ISSUE SHALL last one cycle with mem_en=1 and the latched we/addr/wdata; next state is WAIT for a read or ACK for a write.
REQ-026 WAIT SHALL last MEM_LAT cycles; on its final cycle, mem_rdata is captured into the granted port's rdata register.
REQ-027 ACK SHALL last one cycle, pulsing only the granted port's ack; next state is IDLE.
REQ-028 Read latency SHALL be req-to-ack = MEM_LAT+2 cycles (3 at default); write latency SHALL be 2 cycles.
REQ-029 If req stays high after ack, it SHALL be treated as a new request in the following IDLE cycle.
REQ-030 dbg_halt rising during a CPU transaction SHALL NOT abort it; the transaction completes normally.
REQ-031 A request dropped after being granted SHALL still complete, including its ack pulse.
REQ-032 Input changes after grant SHALL NOT affect mem_* outputs for the granted transaction.
REQ-033 The non-granted port's rdata SHALL be held unchanged.

Reset
REQ-034 Reset assertion SHALL immediately force state=IDLE, mem_en=0, mem_we=0, cpu_ack=0, dbg_ack=0, busy=0 and last_grant=debug.
REQ-035 Reset SHALL clear mem_addr, mem_wdata, cpu_rdata and dbg_rdata to 0.
REQ-036 A transaction interrupted by reset SHALL produce no ack after reset release.

Structure
REQ-037 The state enum and port-select type (PORT_CPU, PORT_DBG) SHALL be placed in shared package mic1_pkg.
REQ-038 Sub-module rr_arb2 SHALL be a two-requester round-robin arbiter holding last_grant; the FSM lives in the top module.

Verification
REQ-039 Preload mem[0x10]=0xDEADBEEF, then CPU read 0x10 -> cpu_ack in cycle 3 after req, cpu_rdata=0xDEADBEEF, dbg_ack never asserted.
REQ-040 Debug write 0x20 <- 0x12345678, then CPU read 0x20 -> exactly one mem_en per access, cpu_rdata=0x12345678.
REQ-041 CPU and debug requests asserted in the same cycle and held for 4 transactions -> grant order CPU, DBG, CPU, DBG.
REQ-042 dbg_halt=1 with both requesting continuously -> only dbg_ack pulses; on dbg_halt=0, CPU is granted within 5 cycles.
REQ-043 rst_n pulsed low during WAIT -> mem_en=0 and busy=0 during reset, no ack afterwards, next request serviced normally.
REQ-044 MEM_LAT=3 build: read -> ack 5 cycles after req with correct data.

Source files
------------

// File: rtl/mic1_pkg.sv
// Shared types for the MIC-1 memory arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, WAIT, ACK)
//   port_t  : requester select (PORT_CPU, PORT_DBG)
//   rr_pick : two-way round-robin pick given the previously granted port
package mic1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_t;

  localparam int MAX_MEM_LAT = 4;

  // On a tie the port that did not win last time gets the slot.
  function automatic port_t rr_pick(input logic req_cpu, input logic req_dbg,
                                    input port_t last);
    port_t p;
    if (req_cpu && req_dbg) p = (last == PORT_CPU) ? PORT_DBG : PORT_CPU;
    else if (req_cpu)       p = PORT_CPU;
    else                    p = PORT_DBG;
    return p;
  endfunction

endpackage

// File: rtl/mic1_mem_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n       : clock, async active-low reset
//   req_cpu, req_dbg : eligible requests (already qualified by the caller)
//   accept           : caller takes the current grant this cycle
//   gnt_vld, gnt     : a grant is available / which port it goes to
// last_grant only moves when a grant is accepted, so a grant offered while
// the FSM is busy does not disturb fairness.
module rr_arb2
  import mic1_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req_cpu,
  input  logic  req_dbg,
  input  logic  accept,
  output logic  gnt_vld,
  output port_t gnt
);

  port_t last_grant;

  always_comb begin
    gnt_vld = req_cpu | req_dbg;
    gnt     = rr_pick(req_cpu, req_dbg, last_grant);
  end

  // Resets to debug so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  last_grant <= PORT_DBG;
    else if (accept && gnt_vld)  last_grant <= gnt;
  end

endmodule

// File: rtl/mic1_mem_arbiter.sv
// mic1_mem_arbiter: shares one single-port main memory between the MIC-1 CPU
// and the UART debug/loader port.
//   cpu_req/we/addr/wdata -> cpu_ack (1-cycle pulse), cpu_rdata (held)
//   dbg_req/we/addr/wdata -> dbg_ack (1-cycle pulse), dbg_rdata (held)
//   dbg_halt              : blocks new CPU grants (in-flight CPU access completes)
//   mem_en/we/addr/wdata  : one-cycle memory strobe per transaction
//   mem_rdata             : read data, valid MEM_LAT cycles after mem_en
//   busy                  : high whenever the FSM is not IDLE
// Read: IDLE -> ISSUE -> WAIT x MEM_LAT -> ACK. Write: IDLE -> ISSUE -> ACK.
module mic1_mem_arbiter
  import mic1_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_t            state, state_nxt;
  port_t             gnt, gnt_q;
  logic              gnt_vld, accept, cpu_elig, wait_last;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, cpu_rdata_q, dbg_rdata_q;
  logic [2:0]        wait_cnt;

  assign cpu_elig  = cpu_req & ~dbg_halt;
  assign wait_last = (wait_cnt == LAT_LAST);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_cpu (cpu_elig),
    .req_dbg (dbg_req),
    .accept  (accept),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = we_q ? ACK : WAIT;
      WAIT:    if (wait_last) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction fields are frozen at grant; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      gnt_q <= gnt;
      if (gnt == PORT_CPU) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end else begin
        we_q    <= dbg_we;
        addr_q  <= dbg_addr;
        wdata_q <= dbg_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wait_cnt <= '0;
    else if (state == ISSUE)  wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + 3'd1;
  end

  // Capture on the last WAIT cycle, which is exactly MEM_LAT after ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (state == WAIT && wait_last) begin
      if (gnt_q == PORT_CPU) cpu_rdata_q <= mem_rdata;
      else                   dbg_rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign cpu_ack   = (state == ACK) && (gnt_q == PORT_CPU);
  assign dbg_ack   = (state == ACK) && (gnt_q == PORT_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule
